// File: rtl/dsp.sv
// 18x18 multiply-accumulate slice modelled on the Spartan-6 DSP48A1: a pre-adder,
// an unsigned multiplier and a 48-bit post-adder, each stage optionally registered.
module dsp #(
    parameter int    A0REG       = 0,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 0,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT     = "DIRECT"
) (
    input  logic        CLK,
    input  logic        RSTA,
    input  logic        RSTB,
    input  logic        RSTC,
    input  logic        RSTD,
    input  logic        RSTM,
    input  logic        RSTP,
    input  logic        RSTCARRYIN,
    input  logic        RSTOPMODE,
    input  logic        CEA,
    input  logic        CEB,
    input  logic        CEC,
    input  logic        CED,
    input  logic        CEM,
    input  logic        CEP,
    input  logic        CECARRYIN,
    input  logic        CEOPMODE,
    input  logic [17:0] A,
    input  logic [17:0] B,
    input  logic [17:0] D,
    input  logic [17:0] BCIN,
    input  logic [47:0] C,
    input  logic [47:0] PCIN,
    input  logic [7:0]  OPMODE,
    input  logic        CARRYIN,
    output logic [17:0] BCOUT,
    output logic [35:0] M,
    output logic [47:0] P,
    output logic [47:0] PCOUT,
    output logic        CARRYOUT,
    output logic        CARRYOUTF
);

    // Pre-adder: D +/- B, wrapping modulo 2^18.
    function automatic logic [17:0] pre_add(input logic sub, input logic [17:0] d, input logic [17:0] b);
        return sub ? (d - b) : (d + b);
    endfunction

    // Post-adder: 49-bit result whose top bit is the carry-out.
    function automatic logic [48:0] post_add(input logic sub, input logic [47:0] z,
                                             input logic [47:0] x, input logic cin);
        logic [48:0] xc;
        xc = {1'b0, x} + {48'd0, cin};
        return sub ? ({1'b0, z} - xc) : ({1'b0, z} + xc);
    endfunction

    logic [17:0] a0_d, a0_q, a0, a1_d, a1_q, a1;
    logic [17:0] b0_d, b0_q, b0, b1_d, b1_q, b1;
    logic [17:0] d_d, d_q, d;
    logic [47:0] c_d, c_q, c;
    logic [7:0]  op_d, op_q, op;
    logic [35:0] m_d, m_q, m;
    logic [47:0] p_d, p_q, p;
    logic        cyi_d, cyi_q, cin;
    logic        cyo_d, cyo_q, co;
    logic [47:0] x_mux, z_mux;
    logic [48:0] sum;

    always_comb begin
        a0_d  = A;
        a0    = (A0REG != 0) ? a0_q : a0_d;
        a1_d  = a0;
        a1    = (A1REG != 0) ? a1_q : a1_d;

        if (B_INPUT == "DIRECT")       b0_d = B;
        else if (B_INPUT == "CASCADE") b0_d = BCIN;
        else                           b0_d = '0;
        b0    = (B0REG != 0) ? b0_q : b0_d;

        d_d   = D;
        d     = (DREG != 0) ? d_q : d_d;
        c_d   = C;
        c     = (CREG != 0) ? c_q : c_d;
        op_d  = OPMODE;
        op    = (OPMODEREG != 0) ? op_q : op_d;

        // B1 sees either the pre-adder result or the raw B0 value.
        b1_d  = op[4] ? pre_add(op[6], d, b0) : b0;
        b1    = (B1REG != 0) ? b1_q : b1_d;

        m_d   = {18'd0, a1} * {18'd0, b1};
        m     = (MREG != 0) ? m_q : m_d;

        cyi_d = (CARRYINSEL == "OPMODE5") ? op[5] : CARRYIN;
        cin   = (CARRYINREG != 0) ? cyi_q : cyi_d;

        case (op[1:0])
            2'b00:   x_mux = '0;
            2'b01:   x_mux = {12'd0, m};
            2'b10:   x_mux = p;
            default: x_mux = {d[11:0], a1, b1};
        endcase
        case (op[3:2])
            2'b00:   z_mux = '0;
            2'b01:   z_mux = PCIN;
            2'b10:   z_mux = p;
            default: z_mux = c;
        endcase

        sum   = post_add(op[7], z_mux, x_mux, cin);
        p_d   = sum[47:0];
        cyo_d = sum[48];
    end

    // P feeds back into the muxes above; with PREG=0 a P-select forms a combinational loop.
    assign p  = (PREG != 0) ? p_q : p_d;
    assign co = (CARRYOUTREG != 0) ? cyo_q : cyo_d;

    always_ff @(posedge CLK or posedge RSTA)
        if (RSTA) begin
            a0_q <= '0;
            a1_q <= '0;
        end else if (CEA) begin
            a0_q <= a0_d;
            a1_q <= a1_d;
        end

    always_ff @(posedge CLK or posedge RSTB)
        if (RSTB) begin
            b0_q <= '0;
            b1_q <= '0;
        end else if (CEB) begin
            b0_q <= b0_d;
            b1_q <= b1_d;
        end

    always_ff @(posedge CLK or posedge RSTC)
        if (RSTC)     c_q <= '0;
        else if (CEC) c_q <= c_d;

    always_ff @(posedge CLK or posedge RSTD)
        if (RSTD)     d_q <= '0;
        else if (CED) d_q <= d_d;

    always_ff @(posedge CLK or posedge RSTM)
        if (RSTM)     m_q <= '0;
        else if (CEM) m_q <= m_d;

    always_ff @(posedge CLK or posedge RSTP)
        if (RSTP)     p_q <= '0;
        else if (CEP) p_q <= p_d;

    always_ff @(posedge CLK or posedge RSTCARRYIN)
        if (RSTCARRYIN) begin
            cyi_q <= 1'b0;
            cyo_q <= 1'b0;
        end else if (CECARRYIN) begin
            cyi_q <= cyi_d;
            cyo_q <= cyo_d;
        end

    always_ff @(posedge CLK or posedge RSTOPMODE)
        if (RSTOPMODE)     op_q <= '0;
        else if (CEOPMODE) op_q <= op_d;

    assign BCOUT     = b1;
    assign M         = m;
    assign P         = p;
    assign PCOUT     = p;
    assign CARRYOUT  = co;
    assign CARRYOUTF = co;

endmodule

// File: tb/tb_dsp.sv
// Directed bench for the dsp MAC slice: inputs change on the falling edge and
// outputs are sampled on the falling edge, with hand-computed expectations.
module tb_dsp;

    logic        CLK = 1'b0;
    logic        RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE;
    logic        CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE;
    logic [17:0] A, B, D, BCIN;
    logic [47:0] C, PCIN;
    logic [7:0]  OPMODE;
    logic        CARRYIN;
    logic [17:0] BCOUT;
    logic [35:0] M;
    logic [47:0] P, PCOUT;
    logic        CARRYOUT, CARRYOUTF;

    int checks = 0;
    int errors = 0;

    dsp dut (
        .CLK(CLK),
        .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD), .RSTM(RSTM), .RSTP(RSTP),
        .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
        .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM), .CEP(CEP),
        .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
        .A(A), .B(B), .D(D), .BCIN(BCIN), .C(C), .PCIN(PCIN),
        .OPMODE(OPMODE), .CARRYIN(CARRYIN),
        .BCOUT(BCOUT), .M(M), .P(P), .PCOUT(PCOUT),
        .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_rst(input logic v);
        RSTA = v; RSTB = v; RSTC = v; RSTD = v;
        RSTM = v; RSTP = v; RSTCARRYIN = v; RSTOPMODE = v;
    endtask

    task automatic drive(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                         input logic [47:0] pcin, input logic [7:0] op);
        A = a; B = b; D = d; PCIN = pcin; OPMODE = op;
    endtask

    initial begin
        set_rst(1'b1);
        CEA = 1; CEB = 1; CEC = 1; CED = 1; CEM = 1; CEP = 1; CECARRYIN = 1; CEOPMODE = 1;
        BCIN = 18'h3FFFF; C = 48'd0; CARRYIN = 1'b1;
        drive(18'd22, 18'd17, 18'd5, 48'd10, 8'h15);

        wait_neg(4);
        check("rst_P",         P,                  48'd0);
        check("rst_PCOUT",     PCOUT,              48'd0);
        check("rst_M",         {12'd0, M},         48'd0);
        check("rst_BCOUT",     {30'd0, BCOUT},     48'd0);
        check("rst_CARRYOUT",  {47'd0, CARRYOUT},  48'd0);
        check("rst_CARRYOUTF", {47'd0, CARRYOUTF}, 48'd0);

        set_rst(1'b0);
        wait_neg(4);
        check("preadd_P",     P,              48'd494);
        check("preadd_PCOUT", PCOUT,          48'd494);
        check("preadd_M",     {12'd0, M},     48'd484);
        check("preadd_BCOUT", {30'd0, BCOUT}, 48'd22);

        drive(18'd5, 18'd3, 18'd6, 48'd10, 8'h55);
        wait_neg(4);
        check("presub_P", P, 48'd25);

        drive(18'd5, 18'd20, 18'd9, 48'd4, 8'h35);
        wait_neg(4);
        check("carryin_P", P, 48'd150);

        drive(18'd1, 18'd5, 18'd6, 48'd3, 8'hD5);
        wait_neg(4);
        check("postsub_P",  P,                 48'd2);
        check("postsub_CO", {47'd0, CARRYOUT}, 48'd0);

        drive(18'd1, 18'd7, 18'd3, 48'd5, 8'h05);
        wait_neg(4);
        check("bypass_P",     P,              48'd12);
        check("bypass_BCOUT", {30'd0, BCOUT}, 48'd7);

        drive(18'd4, 18'd11, 18'd1, 48'd0, 8'h03);
        wait_neg(4);
        check("concat_P", P, {12'd1, 18'd4, 18'd11});

        C = 48'd8;
        OPMODE = 8'h0C;
        wait_neg(4);
        check("cpath_P", P, 48'd8);

        drive(18'd1, 18'd1, 18'd0, 48'hFFFF_FFFF_FFFF, 8'h05);
        wait_neg(4);
        check("wrap_P",         P,                  48'd0);
        check("wrap_CARRYOUT",  {47'd0, CARRYOUT},  48'd1);
        check("wrap_CARRYOUTF", {47'd0, CARRYOUTF}, 48'd1);

        drive(18'd2, 18'd3, 18'd0, 48'd0, 8'h01);
        wait_neg(4);
        check("acc_seed_P", P, 48'd6);

        // Z = P closes the loop: the first edge still uses the old OPMODE.
        OPMODE = 8'h09;
        wait_neg(3);
        check("acc_P", P, 48'd18);

        CEP = 1'b0;
        wait_neg(2);
        check("cep_hold_P", P, 48'd18);

        RSTP = 1'b1;
        #1;
        check("rstp_async_P", P, 48'd0);
        check("rstp_keeps_M", {12'd0, M}, 48'd6);
        wait_neg(1);
        RSTP = 1'b0;
        CEP  = 1'b1;
        wait_neg(1);
        check("rstp_restart_P", P, 48'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
